mem_arbiter: RTL and testbench

- Sits between samming_cpu and ram_adapter; shares the single SRAM path between two masters: instruction fetch (IF) and data access (MEM).
- Lets instructions be fetched from base/ext SRAM instead of test_inst_rom.
- Sequences one access at a time with a ready handshake, fixed MEM priority, IF anti-starvation and a watchdog timeout.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/arb_timeout_counter.sv | 35 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master SRAM arbiter.
package mem_arbiter_pkg;

    localparam int         REG_BUS     = 32;
    localparam logic [3:0] ARB_SEL_ALL = 4'b1111;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IF  = 2'd1,
        ARB_BUSY_MEM = 2'd2,
        ARB_DONE     = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic               we;
        logic [REG_BUS-1:0] addr;
        logic [3:0]         sel;
        logic [REG_BUS-1:0] data;
    } ram_req_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Watchdog for one downstream access: counts stalled BUSY cycles up to a limit.
module arb_timeout_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the stalled cycle whose increment would reach the limit.
    assign expired_o = enable_i && !clear_i && (cnt_q == limit_i - W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one SRAM path between instruction fetch and data access, one access at a time,
// with fixed MEM priority, IF anti-starvation and a watchdog abort.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req_i,
    input  logic [REG_BUS-1:0] if_addr_i,
    output logic [REG_BUS-1:0] if_data_o,
    output logic               if_ready_o,
    input  logic               mem_ce_i,
    input  logic               mem_we_i,
    input  logic [REG_BUS-1:0] mem_addr_i,
    input  logic [3:0]         mem_sel_i,
    input  logic [REG_BUS-1:0] mem_data_i,
    output logic [REG_BUS-1:0] mem_data_o,
    output logic               mem_ready_o,
    output logic               ram_ce_o,
    output logic               ram_we_o,
    output logic [REG_BUS-1:0] ram_addr_o,
    output logic [3:0]         ram_sel_o,
    output logic [REG_BUS-1:0] ram_data_o,
    input  logic [REG_BUS-1:0] ram_data_i,
    input  logic               ram_ready_i,
    output logic               bus_err_o
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TO_LIMIT   = 8'(TIMEOUT_CYCLES);

    arb_state_e         state_q, state_d;
    logic [3:0]         starve_q, starve_d;
    ram_req_t           req_q, req_d;
    logic               ce_q, ce_d;
    logic [REG_BUS-1:0] if_data_q, if_data_d;
    logic [REG_BUS-1:0] mem_data_q, mem_data_d;
    logic               if_ready_q, if_ready_d;
    logic               mem_ready_q, mem_ready_d;
    logic               err_q, err_d;
    logic               busy;
    logic               expired;

    assign busy = (state_q == ARB_BUSY_IF) || (state_q == ARB_BUSY_MEM);

    arb_timeout_counter #(.W(8)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (!busy),
        .enable_i (busy && !ram_ready_i),
        .limit_i  (TO_LIMIT),
        .expired_o(expired)
    );

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        req_d       = req_q;
        ce_d        = ce_q;
        if_data_d   = if_data_q;
        mem_data_d  = mem_data_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // MEM wins unless IF has already been passed over STARVE_LIMIT times.
                if (mem_ce_i && !(if_req_i && (starve_q == STARVE_MAX))) begin
                    state_d  = ARB_BUSY_MEM;
                    starve_d = if_req_i ? starve_q + 4'd1 : 4'd0;
                    ce_d     = 1'b1;
                    req_d    = '{we: mem_we_i, addr: mem_addr_i, sel: mem_sel_i, data: mem_data_i};
                end else if (if_req_i) begin
                    state_d  = ARB_BUSY_IF;
                    starve_d = 4'd0;
                    ce_d     = 1'b1;
                    req_d    = '{we: 1'b0, addr: if_addr_i, sel: ARB_SEL_ALL, data: '0};
                end
            end
            ARB_BUSY_IF, ARB_BUSY_MEM: begin
                if (ram_ready_i || expired) begin
                    state_d = ARB_DONE;
                    ce_d    = 1'b0;
                    req_d   = '0;
                    err_d   = !ram_ready_i;
                    if (state_q == ARB_BUSY_IF) begin
                        if_ready_d = 1'b1;
                        if_data_d  = ram_ready_i ? ram_data_i : '0;
                    end else begin
                        mem_ready_d = 1'b1;
                        mem_data_d  = ram_ready_i ? ram_data_i : '0;
                    end
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            starve_q    <= '0;
            req_q       <= '0;
            ce_q        <= 1'b0;
            if_data_q   <= '0;
            mem_data_q  <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            req_q       <= req_d;
            ce_q        <= ce_d;
            if_data_q   <= if_data_d;
            mem_data_q  <= mem_data_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            err_q       <= err_d;
        end
    end

    assign ram_ce_o    = ce_q;
    assign ram_we_o    = req_q.we;
    assign ram_addr_o  = req_q.addr;
    assign ram_sel_o   = req_q.sel;
    assign ram_data_o  = req_q.data;
    assign if_data_o   = if_data_q;
    assign if_ready_o  = if_ready_q;
    assign mem_data_o  = mem_data_q;
    assign mem_ready_o = mem_ready_q;
    assign bus_err_o   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: adapter model, grant/response scoreboard, scenario tasks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_data_o;
    logic        if_ready_o;
    logic        mem_ce_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_data_i = '0;
    logic [31:0] mem_data_o;
    logic        mem_ready_o;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i = '0;
    logic        ram_ready_i = 1'b0;
    logic        bus_err_o;

    // Grant entries: {we, addr, sel, data}; response entries: {if_rdy, mem_rdy, err, data}.
    logic [68:0] exp_grant_q[$];
    logic [34:0] exp_resp_q[$];

    int          errors = 0;
    int          checks = 0;
    int          wait_cfg = 1;
    logic [31:0] rdata_base = '0;
    logic        stray_ready = 1'b0;
    int          last_ce_len = 0;

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_data_o  (if_data_o),
        .if_ready_o (if_ready_o),
        .mem_ce_i   (mem_ce_i),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_sel_i  (mem_sel_i),
        .mem_data_i (mem_data_i),
        .mem_data_o (mem_data_o),
        .mem_ready_o(mem_ready_o),
        .ram_ce_o   (ram_ce_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_sel_o  (ram_sel_o),
        .ram_data_o (ram_data_o),
        .ram_data_i (ram_data_i),
        .ram_ready_i(ram_ready_i),
        .bus_err_o  (bus_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [136:0] all_outs();
        return {if_data_o, if_ready_o, mem_data_o, mem_ready_o, ram_ce_o, ram_we_o,
                ram_addr_o, ram_sel_o, ram_data_o, bus_err_o};
    endfunction

    task automatic push_grant(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                              input logic [31:0] data);
        exp_grant_q.push_back({we, addr, sel, data});
    endtask

    task automatic push_resp(input logic is_mem, input logic err, input logic [31:0] data);
        exp_resp_q.push_back({~is_mem, is_mem, err, data});
    endtask

    // Adapter model: answers after wait_cfg BUSY cycles (0 = never), garbage data otherwise.
    task automatic run_adapter();
        int  busy_cyc;
        logic hit;
        busy_cyc = 0;
        forever begin
            @(negedge clk);
            if (ram_ce_o) busy_cyc++;
            else busy_cyc = 0;
            hit = ram_ce_o && (wait_cfg != 0) && (busy_cyc == wait_cfg);
            ram_ready_i = hit | stray_ready;
            ram_data_i  = hit ? (rdata_base ^ ram_addr_o) : $urandom();
        end
    endtask

    task automatic run_monitor();
        logic        prev_ce;
        int          ce_len;
        logic [68:0] g, e, held;
        logic [34:0] r, er;
        prev_ce = 1'b0;
        ce_len  = 0;
        held    = '0;
        forever begin
            @(negedge clk);
            g = {ram_we_o, ram_addr_o, ram_sel_o, ram_data_o};
            checks++;
            if (ram_ce_o && !prev_ce) begin
                if (exp_grant_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected: got %h, none expected", g);
                end else begin
                    e = exp_grant_q.pop_front();
                    if (g !== e) begin
                        errors++;
                        $display("FAIL grant: got %h expected %h", g, e);
                    end
                end
                held = g;
            end else if (ram_ce_o) begin
                if (g !== held) begin
                    errors++;
                    $display("FAIL ram_hold: got %h expected %h", g, held);
                end
            end else if (g !== '0) begin
                errors++;
                $display("FAIL ram_idle_zero: got %h expected 0", g);
            end
            if (if_ready_o || mem_ready_o) begin
                r = {if_ready_o, mem_ready_o, bus_err_o, mem_ready_o ? mem_data_o : if_data_o};
                checks++;
                if (exp_resp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got %h, none expected", r);
                end else begin
                    er = exp_resp_q.pop_front();
                    if (r !== er) begin
                        errors++;
                        $display("FAIL resp: got %h expected %h", r, er);
                    end
                end
            end else if (bus_err_o) begin
                checks++;
                errors++;
                $display("FAIL bus_err_alone: got 1 expected 0");
            end
            if (ram_ce_o) begin
                ce_len++;
            end else if (prev_ce) begin
                last_ce_len = ce_len;
                ce_len = 0;
            end
            prev_ce = ram_ce_o;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0; mem_data_i = '0;
        stray_ready = 1'b0;
        repeat (2) @(negedge clk);
        exp_grant_q.delete();
        exp_resp_q.delete();
        rst = 1'b0;
    endtask

    task automatic mem_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                              input logic [31:0] data);
        int n;
        mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = data;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_ready_o !== 1'b1 && n < 200);
        checks++;
        if (mem_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mem_ready_wait: got no ready after %0d cycles expected ready", n);
        end
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0; mem_data_i = '0;
    endtask

    task automatic if_fetch(input logic [31:0] addr);
        int n;
        if_req_i = 1'b1; if_addr_i = addr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (if_ready_o !== 1'b1 && n < 200);
        checks++;
        if (if_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL if_ready_wait: got no ready after %0d cycles expected ready", n);
        end
        if_req_i = 1'b0; if_addr_i = '0;
    endtask

    task automatic check_drained(input string name);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_grant_q.size() != 0 || exp_resp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d grants %0d resps left expected 0 0",
                     name, exp_grant_q.size(), exp_resp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %h expected 0", all_outs());
        end
        apply_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL idle_outs: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_if_only();
        apply_reset();
        wait_cfg = 2;
        rdata_base = 32'h3C01_1230;
        push_grant(1'b0, 32'h0000_0004, 4'hF, 32'h0);
        push_resp(1'b0, 1'b0, 32'h3C01_1234);
        if_fetch(32'h0000_0004);
        @(negedge clk);
        checks++;
        if (last_ce_len != 2) begin
            errors++;
            $display("FAIL if_only_ce_len: got %0d expected 2", last_ce_len);
        end
        check_drained("if_only");
    endtask

    task automatic test_simultaneous();
        apply_reset();
        wait_cfg = 1;
        rdata_base = 32'h1111_0000;
        push_grant(1'b1, 32'h8000_0000, 4'b0011, 32'hDEAD_BEEF);
        push_grant(1'b0, 32'h0000_0010, 4'hF, 32'h0);
        push_resp(1'b1, 1'b0, 32'h1111_0000 ^ 32'h8000_0000);
        push_resp(1'b0, 1'b0, 32'h1111_0000 ^ 32'h0000_0010);
        fork
            mem_access(1'b1, 32'h8000_0000, 4'b0011, 32'hDEAD_BEEF);
            if_fetch(32'h0000_0010);
        join
        @(negedge clk);
        checks++;
        if (mem_data_o !== 32'h9111_0000) begin
            errors++;
            $display("FAIL mem_data_hold: got %h expected %h", mem_data_o, 32'h9111_0000);
        end
        checks++;
        if (if_data_o !== 32'h1111_0010) begin
            errors++;
            $display("FAIL if_data_hold: got %h expected %h", if_data_o, 32'h1111_0010);
        end
        check_drained("simultaneous");
    endtask

    task automatic test_starvation();
        apply_reset();
        wait_cfg = 1;
        rdata_base = 32'h5A5A_0000;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) push_grant(1'b0, 32'h40, 4'hF, 32'h0);
            push_grant(1'b0, 32'h200 + 32'(4 * k), 4'hF, 32'h100 + 32'(k));
        end
        for (int k = 0; k < 6; k++) begin
            if (k == 4) push_resp(1'b0, 1'b0, 32'h5A5A_0040);
            push_resp(1'b1, 1'b0, 32'h5A5A_0000 ^ (32'h200 + 32'(4 * k)));
        end
        fork
            begin
                for (int k = 0; k < 6; k++) mem_access(1'b0, 32'h200 + 32'(4 * k), 4'hF, 32'h100 + 32'(k));
            end
            if_fetch(32'h40);
        join
        check_drained("starvation");
    endtask

    task automatic test_timeout();
        apply_reset();
        wait_cfg = 0;
        push_grant(1'b0, 32'h300, 4'hF, 32'h0);
        push_resp(1'b1, 1'b1, 32'h0);
        mem_access(1'b0, 32'h300, 4'hF, 32'h0);
        @(negedge clk);
        checks++;
        if (last_ce_len != 8) begin
            errors++;
            $display("FAIL timeout_ce_len: got %0d expected 8", last_ce_len);
        end
        wait_cfg = 1;
        rdata_base = 32'hC0DE_0000;
        push_grant(1'b0, 32'h304, 4'h1, 32'h0);
        push_resp(1'b1, 1'b0, 32'hC0DE_0304);
        mem_access(1'b0, 32'h304, 4'h1, 32'h0);
        check_drained("timeout");
    endtask

    task automatic test_race();
        apply_reset();
        wait_cfg = 8;
        rdata_base = 32'h7777_0000;
        push_grant(1'b0, 32'h400, 4'hF, 32'h0);
        push_resp(1'b1, 1'b0, 32'h7777_0400);
        mem_access(1'b0, 32'h400, 4'hF, 32'h0);
        @(negedge clk);
        checks++;
        if (last_ce_len != 8) begin
            errors++;
            $display("FAIL race_ce_len: got %0d expected 8", last_ce_len);
        end
        check_drained("race");
    endtask

    task automatic test_stray_ready();
        apply_reset();
        stray_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({ram_ce_o, if_ready_o, mem_ready_o, bus_err_o} !== 4'b0) begin
                errors++;
                $display("FAIL stray_ready: got %b expected 0000",
                         {ram_ce_o, if_ready_o, mem_ready_o, bus_err_o});
            end
        end
        stray_ready = 1'b0;
        wait_cfg = 1;
        rdata_base = 32'h0BAD_F00D;
        push_grant(1'b0, 32'h80, 4'hF, 32'h0);
        push_resp(1'b0, 1'b0, 32'h0BAD_F08D);
        if_fetch(32'h80);
        check_drained("stray_ready");
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        wait_cfg = 0;
        push_grant(1'b1, 32'h500, 4'hC, 32'h1234_5678);
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h500; mem_sel_i = 4'hC; mem_data_i = 32'h1234_5678;
        repeat (3) @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h20;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL async_reset_outs: got %h expected 0", all_outs());
        end
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0; mem_data_i = '0;
        repeat (2) @(negedge clk);
        exp_grant_q.delete();
        exp_resp_q.delete();
        wait_cfg = 1;
        rdata_base = 32'h2222_0000;
        push_grant(1'b0, 32'h20, 4'hF, 32'h0);
        push_resp(1'b0, 1'b0, 32'h2222_0020);
        rst = 1'b0;
        if_fetch(32'h20);
        check_drained("reset_mid_busy");
    endtask

    initial begin
        fork
            run_adapter();
            run_monitor();
        join_none
        test_reset();
        test_if_only();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_race();
        test_stray_ready();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
